// File: rtl/best_match_pkg.sv
// Shared constants and entry layout for the lowest-cost candidate list.
package best_match_pkg;
  localparam int COORD_W_DEF = 16;
  localparam int COST_W_DEF  = 32;
  localparam int DEPTH_DEF   = 2;

  localparam logic [COST_W_DEF-1:0] COST_MAX = '1;

  typedef struct packed {
    logic                   valid;
    logic [COORD_W_DEF-1:0] x;
    logic [COORD_W_DEF-1:0] y;
    logic [COST_W_DEF-1:0]  cost;
  } entry_t;
endpackage

// File: rtl/best_match_slot.sv
// One sorted-list position: compare, hold/shift/load mux, registered entry.
import best_match_pkg::*;

module best_match_slot #(
  parameter type ent_t = entry_t
) (
  input  logic clk,
  input  logic clr,
  input  logic acc,
  input  ent_t cand,
  input  ent_t prev,
  input  logic shift_in,
  output logic shift_out,
  output logic load,
  output ent_t ent
);

  logic here;

  // strict compare: equal cost lands after existing entries
  assign here      = !ent.valid || (cand.cost < ent.cost);
  assign load      = acc && here && !shift_in;
  assign shift_out = acc && (shift_in || here);

  always_ff @(posedge clk) begin
    if (clr) begin
      ent      <= '0;
      ent.cost <= '1;
    end else if (acc && shift_in) begin
      ent <= prev;
    end else if (load) begin
      ent <= cand;
    end
  end

endmodule

// File: rtl/best_match_reg.sv
// Keeps the DEPTH lowest-cost candidates sorted, best at entry 0.
import best_match_pkg::*;

module best_match_reg #(
  parameter int COORD_W = COORD_W_DEF,
  parameter int COST_W  = COST_W_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               SetZeroes,
  input  logic               Freeze,
  input  logic               CandValid,
  input  logic [COORD_W-1:0] CandX,
  input  logic [COORD_W-1:0] CandY,
  input  logic [COST_W-1:0]  CandCost,
  input  logic [2:0]         RdIdx,
  output logic [COORD_W-1:0] v0,
  output logic [COORD_W-1:0] v1,
  output logic [COST_W-1:0]  BestCost,
  output logic [COORD_W-1:0] RdX,
  output logic [COORD_W-1:0] RdY,
  output logic [COST_W-1:0]  RdCost,
  output logic               RdValid,
  output logic [3:0]         Count,
  output logic               Updated
);

  typedef struct packed {
    logic               valid;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COST_W-1:0]  cost;
  } slot_t;

  slot_t            ents  [DEPTH];
  slot_t            prevs [DEPTH];
  slot_t            cand;
  logic [DEPTH:0]   sh;
  logic [DEPTH-1:0] ld;
  logic             clr;
  logic             acc;

  assign clr = Rst || SetZeroes;
  assign acc = CandValid && !Freeze && !clr;

  always_comb begin
    cand       = '0;
    cand.valid = 1'b1;
    cand.x     = CandX;
    cand.y     = CandY;
    cand.cost  = CandCost;
  end

  assign sh[0] = 1'b0;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    if (i == 0) begin : g_head
      assign prevs[i] = ents[0];
    end else begin : g_tail
      assign prevs[i] = ents[i-1];
    end

    best_match_slot #(.ent_t(slot_t)) u_slot (
      .clk      (Clk),
      .clr      (clr),
      .acc      (acc),
      .cand     (cand),
      .prev     (prevs[i]),
      .shift_in (sh[i]),
      .shift_out(sh[i+1]),
      .load     (ld[i]),
      .ent      (ents[i])
    );
  end

  always_ff @(posedge Clk) begin
    if (clr) begin
      Count   <= '0;
      Updated <= 1'b0;
    end else begin
      Updated <= ld[0];
      if (sh[DEPTH] && Count != 4'(DEPTH))
        Count <= Count + 4'd1;
    end
  end

  // cleared entry 0 already reads as 0/0/all-ones when empty
  assign v0       = ents[0].x;
  assign v1       = ents[0].y;
  assign BestCost = ents[0].cost;

  always_comb begin
    RdValid = 1'b0;
    RdX     = '0;
    RdY     = '0;
    RdCost  = '1;
    for (int i = 0; i < DEPTH; i++) begin
      if (RdIdx == 3'(i)) begin
        RdValid = ents[i].valid;
        RdX     = ents[i].x;
        RdY     = ents[i].y;
        RdCost  = ents[i].cost;
      end
    end
  end

endmodule

// File: tb/tb_best_match_reg.sv
// Directed checks of the sorted lowest-cost register, DEPTH=2.
import best_match_pkg::*;

module tb_best_match_reg;

  logic        Clk = 1'b0;
  logic        Rst, SetZeroes, Freeze, CandValid;
  logic [15:0] CandX, CandY;
  logic [31:0] CandCost;
  logic [2:0]  RdIdx;
  logic [15:0] v0, v1, RdX, RdY;
  logic [31:0] BestCost, RdCost;
  logic        RdValid, Updated;
  logic [3:0]  Count;

  int n_cmp = 0;
  int n_bad = 0;

  best_match_reg u_dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .SetZeroes(SetZeroes),
    .Freeze   (Freeze),
    .CandValid(CandValid),
    .CandX    (CandX),
    .CandY    (CandY),
    .CandCost (CandCost),
    .RdIdx    (RdIdx),
    .v0       (v0),
    .v1       (v1),
    .BestCost (BestCost),
    .RdX      (RdX),
    .RdY      (RdY),
    .RdCost   (RdCost),
    .RdValid  (RdValid),
    .Count    (Count),
    .Updated  (Updated)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic cand(input logic [15:0] x, input logic [15:0] y,
                      input logic [31:0] c);
    CandValid = 1'b1;
    CandX     = x;
    CandY     = y;
    CandCost  = c;
  endtask

  task automatic top(input string tag, input logic [15:0] ex,
                     input logic [15:0] ey, input logic [31:0] ec,
                     input logic [3:0] en, input logic eu);
    chk({tag, ".v0"}, 64'(v0), 64'(ex));
    chk({tag, ".v1"}, 64'(v1), 64'(ey));
    chk({tag, ".best"}, 64'(BestCost), 64'(ec));
    chk({tag, ".count"}, 64'(Count), 64'(en));
    chk({tag, ".upd"}, 64'(Updated), 64'(eu));
  endtask

  task automatic rd(input string tag, input logic [2:0] idx,
                    input logic ev, input logic [15:0] ex,
                    input logic [15:0] ey, input logic [31:0] ec);
    RdIdx = idx;
    #1;
    chk({tag, ".rdv"}, 64'(RdValid), 64'(ev));
    chk({tag, ".rdx"}, 64'(RdX), 64'(ex));
    chk({tag, ".rdy"}, 64'(RdY), 64'(ey));
    chk({tag, ".rdc"}, 64'(RdCost), 64'(ec));
  endtask

  initial begin
    Rst = 1'b1; SetZeroes = 1'b0; Freeze = 1'b0;
    CandValid = 1'b1; CandX = 16'd11; CandY = 16'd12;
    CandCost = 32'd3; RdIdx = 3'd0;
    tick();
    tick();
    top("reset", 16'd0, 16'd0, COST_MAX, 4'd0, 1'b0);
    rd("reset0", 3'd0, 1'b0, 16'd0, 16'd0, COST_MAX);

    Rst = 1'b0;
    cand(16'd3, 16'd4, 32'd50);
    tick();
    top("ins50", 16'd3, 16'd4, 32'd50, 4'd1, 1'b1);

    cand(16'd7, 16'd1, 32'd20);
    tick();
    top("ins20", 16'd7, 16'd1, 32'd20, 4'd2, 1'b1);
    rd("ins20", 3'd1, 1'b1, 16'd3, 16'd4, 32'd50);

    cand(16'd9, 16'd9, 32'd20);
    tick();
    top("tie20", 16'd7, 16'd1, 32'd20, 4'd2, 1'b0);
    rd("tie20", 3'd1, 1'b1, 16'd9, 16'd9, 32'd20);

    cand(16'd1, 16'd1, 32'd60);
    tick();
    top("drop60", 16'd7, 16'd1, 32'd20, 4'd2, 1'b0);
    rd("drop60", 3'd1, 1'b1, 16'd9, 16'd9, 32'd20);

    SetZeroes = 1'b1;
    cand(16'd4, 16'd4, 32'd5);
    tick();
    SetZeroes = 1'b0;
    CandValid = 1'b0;
    top("clr", 16'd0, 16'd0, COST_MAX, 4'd0, 1'b0);
    rd("clr", 3'd0, 1'b0, 16'd0, 16'd0, COST_MAX);

    Freeze = 1'b1;
    cand(16'd2, 16'd2, 32'd1);
    tick();
    top("frz", 16'd0, 16'd0, COST_MAX, 4'd0, 1'b0);
    Freeze = 1'b0;
    tick();
    top("unfrz", 16'd2, 16'd2, 32'd1, 4'd1, 1'b1);
    CandValid = 1'b0;
    tick();
    top("pulse", 16'd2, 16'd2, 32'd1, 4'd1, 1'b0);

    Freeze = 1'b1;
    SetZeroes = 1'b1;
    tick();
    Freeze = 1'b0;
    SetZeroes = 1'b0;
    top("frzclr", 16'd0, 16'd0, COST_MAX, 4'd0, 1'b0);

    cand(16'd5, 16'd6, 32'd10);
    tick();
    cand(16'd8, 16'd8, 32'd30);
    tick();
    CandValid = 1'b0;
    top("pre_rst", 16'd5, 16'd6, 32'd10, 4'd2, 1'b0);
    rd("pre_rst", 3'd1, 1'b1, 16'd8, 16'd8, 32'd30);

    Rst = 1'b1;
    cand(16'd1, 16'd1, 32'd2);
    tick();
    Rst = 1'b0;
    CandValid = 1'b0;
    top("midrst", 16'd0, 16'd0, COST_MAX, 4'd0, 1'b0);
    rd("idx7", 3'd7, 1'b0, 16'd0, 16'd0, COST_MAX);
    rd("idx2", 3'd2, 1'b0, 16'd0, 16'd0, COST_MAX);
    rd("idx1", 3'd1, 1'b0, 16'd0, 16'd0, COST_MAX);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
